// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - 4-digit multiplexed common-anode 7-segment driver for packed BCD (optional blink: BCD_SCAN_BLINK_EN)
module bcd_scan_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
`ifdef BCD_SCAN_BLINK_EN
    ,
    parameter int BLINK_SLOTS = 100
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
`ifdef BCD_SCAN_BLINK_EN
    input  logic        blink_in,
`endif
    output logic [3:0]  an_out,
    output logic [6:0]  seg_out,
    output logic        err_out
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] TERM_CNT  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

    logic [15:0]   r_shadow;
    logic          r_blz;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_err;

    logic [3:0]    w_digit;
    logic          w_supp;
    logic          w_blank;
    logic          w_term;
    logic          w_dark;
    logic          w_bad_in;

    // Active-low segment pattern {g,f,e,d,c,b,a}; anything above 9 shows a dash
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign w_bad_in = (bcd_in[3:0] > 4'd9) || (bcd_in[7:4] > 4'd9) ||
                      (bcd_in[11:8] > 4'd9) || (bcd_in[15:12] > 4'd9);
    assign w_term   = (r_presc == TERM_CNT);
    assign w_blank  = (r_presc < BLANK_END);

    // Select the current digit and decide whether it is a suppressed leading zero
    always_comb begin
        w_digit = 4'd0;
        w_supp  = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit = r_shadow[3:0];
                w_supp  = 1'b0;
            end
            2'd1: begin
                w_digit = r_shadow[7:4];
                w_supp  = r_blz && (r_shadow[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_shadow[11:8];
                w_supp  = r_blz && (r_shadow[15:8] == 8'd0);
            end
            default: begin
                w_digit = r_shadow[15:12];
                w_supp  = r_blz && (r_shadow[15:12] == 4'd0);
            end
        endcase
    end

`ifdef BCD_SCAN_BLINK_EN
    localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;

    // Count full scans while blinking; every other group of BLINK_SLOTS scans is dark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (!blink_in) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (w_term && (r_idx == 2'd3)) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_dark = w_blank || w_supp || (blink_in && r_blink_ph);
`else
    assign w_dark = w_blank || w_supp;
`endif

    // Shadow word and error flag; only load touches them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= 16'd0;
            r_blz    <= 1'b0;
            r_err    <= 1'b0;
        end else if (load) begin
            r_shadow <= bcd_in;
            r_blz    <= blank_lz;
            r_err    <= w_bad_in;
        end
    end

    // Slot prescaler and digit index; the index advances on each prescaler wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (w_term) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Registered pin drivers, one cycle behind the scan state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else if (w_dark) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= f_seg(w_digit);
        end
    end

    assign an_out  = r_an;
    assign seg_out = r_seg;
    assign err_out = r_err;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - scoreboard bench for bcd_scan_display against a slot-level reference model
module tb_bcd_scan_display;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        err_out;

    bcd_scan_display #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .an_out   (an_out),
        .seg_out  (seg_out),
        .err_out  (err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    int          m_c;
    logic [15:0] m_word;
    logic        m_blz;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (v > 9) return 7'h3F;
        return tbl[v];
    endfunction

    function automatic logic has_bad(input logic [15:0] w);
        int wi;
        wi = int'(w);
        for (int i = 0; i < 4; i++)
            if (((wi >> (4 * i)) & 15) > 9) return 1'b1;
        return 1'b0;
    endfunction

    // Expected pins after the edge that ends cycle c, given the word displayed during it
    function automatic exp_t model(input int c, input logic [15:0] w, input logic b, input logic e);
        exp_t r;
        int p, d, wi, nib, upper;
        p     = c % RD;
        d     = (c / RD) % 4;
        wi    = int'(w);
        nib   = (wi >> (4 * d)) & 15;
        upper = wi >> (4 * d);
        r.err = e;
        if (p < BC || (b && d > 0 && upper == 0)) begin
            r.an  = 4'hF;
            r.seg = 7'h7F;
        end else begin
            r.an  = 4'hF & ~(4'd1 << d);
            r.seg = seg_of(nib);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_c    = 0;
        m_word = 16'd0;
        m_blz  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] w, input logic b);
        exp_t e;
        load     = ld;
        bcd_in   = w;
        blank_lz = b;
        @(posedge clk);
        e = model(m_c, m_word, m_blz, ld ? has_bad(w) : m_err);
        sbq.push_back(e);
        if (ld) begin
            m_word = w;
            m_blz  = b;
            m_err  = has_bad(w);
        end
        m_c++;
        #1;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 1'($urandom));
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++)
            w[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return w;
    endfunction

    // Monitor: pop one expectation per cycle and compare against the pins
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
            end else if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("an", 32'(an_out), 32'(e.an));
                chk("seg", 32'(seg_out), 32'(e.seg));
                chk("err", 32'(err_out), 32'(e.err));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'd0;
        blank_lz = 1'b0;
        model_reset();
        #12;
        chk("reset_an", 32'(an_out), 32'hF);
        chk("reset_seg", 32'(seg_out), 32'h7F);
        chk("reset_err", 32'(err_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(3);
        chk("first_drive_an", 32'(an_out), 32'hE);
        chk("first_drive_seg", 32'(seg_out), 32'h40);

        step(1'b1, 16'h1234, 1'b0);
        idle(40);
        step(1'b1, 16'h0045, 1'b1);
        idle(36);
        step(1'b1, 16'h0000, 1'b1);
        idle(36);
        step(1'b1, 16'h9A07, 1'b0);
        chk("err_set", 32'(err_out), 32'h1);
        idle(36);
        step(1'b1, 16'h0007, 1'b0);
        chk("err_clear", 32'(err_out), 32'h0);
        idle(20);

        while (m_c % 32 != 7) idle(1);
        step(1'b1, 16'h8888, 1'b0);
        idle(40);

        step(1'b1, 16'h9A07, 1'b0);
        idle(8);
        while (m_c % RD != 4) idle(1);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_an", 32'(an_out), 32'hF);
        chk("midreset_seg", 32'(seg_out), 32'h7F);
        chk("midreset_err", 32'(err_out), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(3);
        chk("restart_an", 32'(an_out), 32'hE);
        chk("restart_seg", 32'(seg_out), 32'h40);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) step(1'b1, rand_word(), 1'($urandom));
            else idle(1);
        end

        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Downstream consumer of the binary-to-BCD conversion stage. Latches a 4-digit packed BCD word, then time-multiplexes it onto a common-anode 4-digit 7-segment display. Provides a refresh prescaler, an anti-ghosting blank window, optional leading-zero blanking and a flag for invalid BCD digits. Drives board pins directly; all outputs are registered.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; legal range 4..2^20.
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
bcd_in  input  16  packed BCD; [3:0] is digit 0 (least significant), [15:12] is digit 3
load  input  1  single-cycle strobe; captures bcd_in and blank_lz
blank_lz  input  1  leading-zero blanking request; sampled only on load
an_out  output  4  anode enables, active low; bit n selects digit n
seg_out  output  7  segments {g,f,e,d,c,b,a}, active low
err_out  output  1  high while the latched word contains any nibble > 9

Behaviour:
- Reset (async assert, sync release):
  - shadow word = 0, latched blank_lz = 0, prescaler = 0, digit index = 0.
  - an_out = 4'b1111, seg_out = 7'h7F, err_out = 0.
- Load:
  - When load = 1 at a rising edge, the shadow word takes bcd_in and the blank flag takes blank_lz.
  - err_out updates on the same edge.
  - The scan reads only the shadow word, so no mid-slot tearing occurs from bcd_in changes.
  - Prescaler and index are not disturbed by load.
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the index advances 0→1→2→3→0.
- Scan state per slot:
  - BLANK (prescaler < BLANK_CYC): an_out = 4'b1111, seg_out = 7'h7F.
  - DRIVE (otherwise): an_out has the index bit low; seg_out is the decoded digit.
- Output timing: an_out and seg_out are registered, so they lag the prescaler/index state by exactly 1 cycle.
- Segment decode (active low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any nibble >9 decodes to dash 3F (g only).
- Leading-zero blanking, when the latched flag = 1:
  - Digit n (n = 3..1) is suppressed if it and all higher digits are 0.
  - Suppressed means its DRIVE phase keeps an_out = 4'b1111.
  - Digit 0 is never suppressed. A value of 0 shows a single "0".
  - An invalid nibble counts as nonzero.
- Simultaneous load and terminal count: both take effect on the same edge. The next slot displays the new data.
- Load while in BLANK: shadow updates normally; no change to slot timing.
- Reset mid-scan: outputs go dark immediately (asynchronously); the scan restarts from digit 0 in BLANK.
- Full period: 4*REFRESH_DIV cycles.
- Width rules: the prescaler width is the minimum needed for REFRESH_DIV-1. No arithmetic is performed on BCD data.

Optional Feature:
- Macro: BCD_SCAN_BLINK_EN.
- When defined:
  - Adds input blink_in (1 bit) and parameter BLINK_SLOTS (default 100).
  - A blink counter increments on each index wrap 3→0.
  - While blink_in = 1, every other group of BLINK_SLOTS full scans forces an_out = 4'b1111.
  - The blink counter resets on rst and when blink_in falls.
- When undefined: no blink_in port or logic; display behaviour is exactly as above.

Test Plan:
(Bench uses REFRESH_DIV = 8, BLANK_CYC = 2.)
- Reset check: assert rst mid-slot → an_out = 4'hF, seg_out = 7'h7F, err_out = 0 within the same cycle; after release, the first DRIVE is digit 0 showing 7'h40 at cycle 3.
- Basic display: load 16'h1234, blank_lz = 0 → slots show seg 19 (an 1110), 30 (1101), 24 (1011), 79 (0111); each DRIVE lasts 6 cycles after a 2-cycle dark window; period 32 cycles.
- Leading-zero blanking: load 16'h0045, blank_lz = 1 → digits 3 and 2 are dark for their whole slots; digits 1 and 0 show 19 and 12. Then load 16'h0000, blank_lz = 1 → only digit 0 lit, showing 40.
- Invalid digit: load 16'h9A07 → err_out = 1 on the next edge; digit 2 shows 3F, digit 3 shows 10. Then load 16'h0007 → err_out = 0.
- Load collision: assert load with 16'h8888 on the terminal-count cycle of slot 0 → slot 1 DRIVE shows 00; no slot is shortened or stretched.
- Blink (with BCD_SCAN_BLINK_EN, BLINK_SLOTS = 2): blink_in = 1 → 2 scans lit, 2 scans dark, repeating; dropping blink_in restores continuous display on the next slot.
